// File: rtl/data_mem_arbiter.sv
// Round-robin two-port doubleword arbiter for the byte-wide data array.
// Each granted access is serialized into eight little-endian byte beats.
module data_mem_arbiter #(
   parameter int MEM_BYTES = 64,
   parameter int MEM_AW    = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [63:0]       addr0,
   input  logic [63:0]       addr1,
   input  logic [63:0]       wdata0,
   input  logic [63:0]       wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [63:0]       rdata0,
   output logic [63:0]       rdata1,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [2:0]        beat;
   logic              last;
   logic              gnt;
   logic              lwe;
   logic [MEM_AW-1:0] laddr;
   logic [63:0]       lwdata;
   logic [63:0]       rbuf;

   logic        any;
   logic        pick;
   logic        sel_we;
   logic [63:0] sel_addr;
   logic [63:0] sel_wdata;
   logic        legal;

   always_comb begin
      any       = req0 | req1;
      pick      = (req0 && req1) ? ~last : req1;
      sel_we    = pick ? we1 : we0;
      sel_addr  = pick ? addr1 : addr0;
      sel_wdata = pick ? wdata1 : wdata0;
      legal     = (sel_addr <= 64'(MEM_BYTES - 8)) &&
                  (sel_addr[63:MEM_AW] == '0);
   end

   // Beat address cannot wrap once the legality check has passed.
   assign mem_addr  = laddr + {{(MEM_AW-3){1'b0}}, beat};
   assign mem_wdata = lwdata[{beat, 3'b000} +: 8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         beat   <= 3'd0;
         last   <= 1'b1;
         gnt    <= 1'b0;
         lwe    <= 1'b0;
         laddr  <= '0;
         lwdata <= '0;
         rbuf   <= '0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
         mem_we <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  gnt    <= pick;
                  last   <= pick;
                  lwe    <= sel_we;
                  laddr  <= sel_addr[MEM_AW-1:0];
                  lwdata <= sel_wdata;
                  rbuf   <= '0;
                  beat   <= 3'd0;
                  if (legal) begin
                     state  <= BUSY;
                     mem_we <= sel_we;
                  end else begin
                     // Rejected: skip the beats and answer next cycle.
                     state <= DONE;
                     if (pick) begin
                        ack1   <= 1'b1;
                        err1   <= 1'b1;
                        rdata1 <= '0;
                     end else begin
                        ack0   <= 1'b1;
                        err0   <= 1'b1;
                        rdata0 <= '0;
                     end
                  end
               end
            end
            BUSY: begin
               if (!lwe)
                  rbuf[{beat, 3'b000} +: 8] <= mem_rdata;
               beat <= beat + 3'd1;
               if (beat == 3'd7) begin
                  state  <= DONE;
                  mem_we <= 1'b0;
                  if (gnt) begin
                     ack1 <= 1'b1;
                     if (!lwe)
                        rdata1 <= {mem_rdata, rbuf[55:0]};
                  end else begin
                     ack0 <= 1'b1;
                     if (!lwe)
                        rdata0 <= {mem_rdata, rbuf[55:0]};
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               beat  <= 3'd0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural byte array.
// Directed accesses push expected acks; a negedge monitor pops and compares.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic [63:0] addr0 = '0, addr1 = '0;
   logic [63:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, err0, err1;
   logic [63:0] rdata0, rdata1;
   logic [5:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [0:63];
   logic [1:0]  fill = 2'd0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int we_cnt = 0;

   typedef struct {
      logic        port;
      logic        err;
      logic [63:0] rd;
      logic        chk_rd;
   } exp_t;
   exp_t q[$];

   data_mem_arbiter #(.MEM_BYTES(64), .MEM_AW(6)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
      else if (fill == 2'd1)
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      else if (fill == 2'd2)
         for (int i = 16; i < 24; i++) mem[i] <= 8'hEE;
   end

   always @(negedge clk)
      if (mem_we) we_cnt <= we_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mem64(input int a);
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[a + k];
      return v;
   endfunction

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && (ack0 || ack1)) begin
         exp_t e;
         if (ack0 && ack1) begin
            chk("dual_ack", 64'(ack1), 64'(0));
         end else if (q.size() == 0) begin
            chk("unexpected_ack", 64'(ack1), 64'(2));
         end else begin
            e = q.pop_front();
            chk("ack_port", 64'(ack1), 64'(e.port));
            chk("ack_err", 64'(ack1 ? err1 : err0), 64'(e.err));
            if (e.chk_rd)
               chk("rdata", ack1 ? rdata1 : rdata0, e.rd);
         end
      end
   end

   task automatic access(input logic port, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_rd,
                         input logic chk_rd);
      int n;
      int base;
      logic seen;
      @(posedge clk);
      #1;
      q.push_back('{port, exp_err, exp_rd, chk_rd});
      base = we_cnt;
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (port ? ack1 : ack0) seen = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      if (!seen) begin
         chk("ack_timeout", 64'(n), 64'(0));
         q.delete();
      end else begin
         chk("ack_latency", 64'(n), exp_err ? 64'(2) : 64'(10));
         chk("we_cycles", 64'(we_cnt - base),
             (we && !exp_err) ? 64'(8) : 64'(0));
      end
   endtask

   initial begin
      int t [4];
      int k;
      logic [63:0] r0;

      fill = 2'd1;
      repeat (3) @(posedge clk);
      #1 fill = 2'd0;
      @(negedge clk);
      chk("rst_ack0", 64'(ack0), 64'(0));
      chk("rst_ack1", 64'(ack1), 64'(0));
      chk("rst_err", 64'({err0, err1}), 64'(0));
      chk("rst_rdata0", rdata0, 64'(0));
      chk("rst_rdata1", rdata1, 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      reset = 1'b0;

      access(1'b1, 1'b0, 64'd3, '0, 1'b0, 64'h0A09080706050403, 1'b1);
      access(1'b0, 1'b1, 64'd8, 64'h1122334455667788, 1'b0, '0, 1'b0);
      chk("store_bytes_8", mem64(8), 64'h1122334455667788);
      chk("neighbour_7", 64'(mem[7]), 64'h07);
      chk("neighbour_16", 64'(mem[16]), 64'h10);
      access(1'b0, 1'b0, 64'd8, '0, 1'b0, 64'h1122334455667788, 1'b1);
      access(1'b1, 1'b0, 64'd56, '0, 1'b0, 64'h3F3E3D3C3B3A3938, 1'b1);
      access(1'b0, 1'b0, 64'd57, '0, 1'b1, 64'h0, 1'b1);
      access(1'b0, 1'b0, 64'h100, '0, 1'b1, 64'h0, 1'b1);
      access(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b1, 64'h0, 1'b1);

      // Abort a store at beat 4 with an asynchronous reset.
      @(posedge clk);
      #1 reset = 1'b1;
      fill = 2'd2;
      @(posedge clk);
      #1 fill = 2'd0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 64'd16;
      wdata0 = 64'h8877665544332211;
      repeat (6) @(negedge clk);
      chk("beat4_we", 64'(mem_we), 64'(1));
      chk("beat4_addr", 64'(mem_addr), 64'd20);
      chk("beat4_wdata", 64'(mem_wdata), 64'h55);
      reset = 1'b1;
      req0 = 1'b0;
      #1;
      chk("abort_mem_we", 64'(mem_we), 64'(0));
      chk("abort_mem_addr", 64'(mem_addr), 64'(0));
      chk("abort_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("abort_ack", 64'({ack0, ack1, err0, err1}), 64'(0));
      chk("abort_rdata1", rdata1, 64'(0));
      chk("abort_bytes", mem64(16), 64'hEEEEEEEE44332211);

      // Contention from reset: both ports hold stores.
      req0 = 1'b1; we0 = 1'b1; addr0 = 64'd16;
      wdata0 = 64'hA7A6A5A4A3A2A1A0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 64'd24;
      wdata1 = 64'hB7B6B5B4B3B2B1B0;
      q.push_back('{1'b0, 1'b0, 64'h0, 1'b0});
      q.push_back('{1'b1, 1'b0, 64'h0, 1'b0});
      q.push_back('{1'b0, 1'b0, 64'h0, 1'b0});
      q.push_back('{1'b1, 1'b0, 64'h0, 1'b0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      k = 0;
      for (int n = 0; n < 80 && k < 4; n++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            t[k] = cyc;
            k++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("contend_acks", 64'(k), 64'(4));
      if (k == 4) begin
         chk("contend_gap1", 64'(t[1] - t[0]), 64'(10));
         chk("contend_gap2", 64'(t[2] - t[1]), 64'(10));
         chk("contend_gap3", 64'(t[3] - t[2]), 64'(10));
      end else begin
         q.delete();
      end
      chk("contend_mem16", mem64(16), 64'hA7A6A5A4A3A2A1A0);
      chk("contend_mem24", mem64(24), 64'hB7B6B5B4B3B2B1B0);

      // Port 1 alone, repeatedly; port 0 result must stay put.
      access(1'b0, 1'b0, 64'd8, '0, 1'b0, 64'h1122334455667788, 1'b1);
      r0 = 64'h1122334455667788;
      access(1'b1, 1'b0, 64'd0, '0, 1'b0, 64'h0706050403020100, 1'b1);
      access(1'b1, 1'b0, 64'd12, '0, 1'b0, 64'hA3A2A1A011223344, 1'b1);
      access(1'b1, 1'b0, 64'd24, '0, 1'b0, 64'hB7B6B5B4B3B2B1B0, 1'b1);
      chk("rdata0_held", rdata0, r0);

      repeat (4) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
